opb_reg_slave_arbiter: RTL and testbench

- OPB front-end shared by a bank of C_NUM_SLAVES software-register slaves, for example several simulink2ppc registers.
- Decodes one contiguous address window into one-hot per-slave selects and runs one transfer at a time.
- Collects slave responses and returns a single registered, OR-bus-safe response to the OPB master.
- Enforces its own timeout so that a hung register returns Sl_errAck instead of stalling the bus.

---
 rtl/opb_reg_slave_arbiter.sv | 170 +++++++++++++++++
 tb/tb_opb_reg_slave_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/opb_reg_slave_arbiter.sv
// rtl/opb_reg_slave_arbiter.sv - OPB window decoder/arbiter for a bank of register slaves; OPB_ARB_STATUS_REG_EN adds a status word
module opb_reg_slave_arbiter #(
    parameter int          C_NUM_SLAVES = 4,
    parameter logic [31:0] C_BASEADDR   = 32'h0100E000,
    parameter int          C_SPAN_LOG2  = 8,
    parameter int          C_TIMEOUT    = 16,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]          OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]        OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]          OPB_DBus,
    input  logic                             OPB_RNW,
    input  logic                             OPB_select,
    input  logic                             OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]          Sl_DBus,
    output logic                             Sl_errAck,
    output logic                             Sl_retry,
    output logic                             Sl_toutSup,
    output logic                             Sl_xferAck,
    output logic [C_NUM_SLAVES-1:0]          M_select,
    output logic [0:C_OPB_AWIDTH-1]          M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]        M_BE,
    output logic [0:C_OPB_DWIDTH-1]          M_DBus,
    output logic                             M_RNW,
    output logic                             M_seqAddr,
    input  logic [C_OPB_DWIDTH*C_NUM_SLAVES-1:0] S_DBus,
    input  logic [C_NUM_SLAVES-1:0]          S_xferAck,
    input  logic [C_NUM_SLAVES-1:0]          S_errAck,
    output logic [15:0]                      err_count
);
    localparam int IDX_W = (C_NUM_SLAVES > 1) ? $clog2(C_NUM_SLAVES) : 1;
    localparam logic [C_OPB_AWIDTH-1:0] BASE = C_OPB_AWIDTH'(C_BASEADDR);
    localparam logic [C_OPB_AWIDTH-1:0] WIN  = C_OPB_AWIDTH'(C_NUM_SLAVES) << C_SPAN_LOG2;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx_q, idx_n, addr_idx;
    logic [7:0]              cnt_q, cnt_n;
    logic [C_OPB_AWIDTH-1:0] addr, offset;
    logic                    slv_hit, capture, xfer_n, err_n, inc_err, clr_err;
    logic [C_OPB_DWIDTH-1:0] dbus_n, rd_slice;

    assign addr     = OPB_ABus;
    assign offset   = addr - BASE;
    assign slv_hit  = (addr >= BASE) && (offset < WIN);
    assign addr_idx = IDX_W'(offset >> C_SPAN_LOG2);

`ifdef OPB_ARB_STATUS_REG_EN
    logic                    stat_hit;
    logic [7:0]              last_err_idx;
    logic [C_OPB_DWIDTH-1:0] status_word;
    assign stat_hit    = (addr >= BASE) && (offset >= WIN) && (offset < WIN + C_OPB_AWIDTH'(4));
    assign status_word = C_OPB_DWIDTH'({err_count, last_err_idx, 8'h00});
`endif

    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < C_NUM_SLAVES; i++)
            if (IDX_W'(i) == idx_q) rd_slice = S_DBus[i*C_OPB_DWIDTH +: C_OPB_DWIDTH];
    end

    // Abort outranks acks; a slave ack in the last ACTIVE cycle outranks the timeout.
    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        capture = 1'b0;
        xfer_n  = 1'b0;
        err_n   = 1'b0;
        dbus_n  = '0;
        inc_err = 1'b0;
        clr_err = 1'b0;
        case (state)
            IDLE: begin
                if (OPB_select) begin
                    if (slv_hit) begin
                        capture = 1'b1;
                        idx_n   = addr_idx;
                        cnt_n   = '0;
                        state_n = ACTIVE;
                    end
`ifdef OPB_ARB_STATUS_REG_EN
                    else if (stat_hit) begin
                        state_n = DONE;
                        xfer_n  = 1'b1;
                        if (OPB_RNW) dbus_n = status_word;
                        else         clr_err = 1'b1;
                    end
`endif
                end
            end
            ACTIVE: begin
                if (!OPB_select) begin
                    state_n = IDLE;
                end else if (S_errAck[idx_q]) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                    inc_err = 1'b1;
                end else if (S_xferAck[idx_q]) begin
                    state_n = DONE;
                    xfer_n  = 1'b1;
                    if (M_RNW) dbus_n = rd_slice;
                end else if (cnt_q == 8'(C_TIMEOUT - 1)) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                    inc_err = 1'b1;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst) begin
            state      <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            M_ABus     <= '0;
            M_BE       <= '0;
            M_DBus     <= '0;
            M_RNW      <= 1'b0;
            M_seqAddr  <= 1'b0;
            Sl_xferAck <= 1'b0;
            Sl_errAck  <= 1'b0;
            Sl_DBus    <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            idx_q      <= idx_n;
            cnt_q      <= cnt_n;
            Sl_xferAck <= xfer_n;
            Sl_errAck  <= err_n;
            Sl_DBus    <= dbus_n;
            if (capture) begin
                M_ABus    <= OPB_ABus;
                M_BE      <= OPB_BE;
                M_DBus    <= OPB_DBus;
                M_RNW     <= OPB_RNW;
                M_seqAddr <= OPB_seqAddr;
            end
            if (clr_err)
                err_count <= '0;
            else if (inc_err && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

`ifdef OPB_ARB_STATUS_REG_EN
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst || clr_err) last_err_idx <= '0;
        else if (inc_err)        last_err_idx <= 8'(idx_q);
    end
`endif

    always_comb begin
        M_select = '0;
        if (state == ACTIVE) M_select[idx_q] = 1'b1;
    end

    assign Sl_toutSup = (state == ACTIVE);
    assign Sl_retry   = 1'b0;

endmodule

// File: tb/tb_opb_reg_slave_arbiter.sv
// tb/tb_opb_reg_slave_arbiter.sv - directed plus randomized bench for opb_reg_slave_arbiter against a cycle-count model
module tb_opb_reg_slave_arbiter;
    localparam int          N    = 4;
    localparam int          T    = 16;
    localparam logic [31:0] BASE = 32'h0100E000;
    localparam int          SPAN = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [0:31]   opb_abus = '0;
    logic [0:3]    opb_be = '0;
    logic [0:31]   opb_dbus = '0;
    logic          opb_rnw = 1'b0, opb_select = 1'b0, opb_seq = 1'b0;
    logic [0:31]   sl_dbus;
    logic          sl_err, sl_retry, sl_tout, sl_xfer;
    logic [N-1:0]  m_select;
    logic [0:31]   m_abus, m_dbus;
    logic [0:3]    m_be;
    logic          m_rnw, m_seq;
    logic [32*N-1:0] s_dbus = '0;
    logic [N-1:0]  s_xfer = '0, s_err = '0;
    logic [15:0]   err_count;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_errs = '0;
    logic [31:0] exp_mabus = '0, exp_mdbus = '0;
    logic [3:0]  exp_mbe = '0;
    logic        exp_mrnw = 1'b0, exp_mseq = 1'b0;

    always #5 clk = ~clk;

    opb_reg_slave_arbiter dut (
        .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(opb_abus), .OPB_BE(opb_be),
        .OPB_DBus(opb_dbus), .OPB_RNW(opb_rnw), .OPB_select(opb_select),
        .OPB_seqAddr(opb_seq), .Sl_DBus(sl_dbus), .Sl_errAck(sl_err),
        .Sl_retry(sl_retry), .Sl_toutSup(sl_tout), .Sl_xferAck(sl_xfer),
        .M_select(m_select), .M_ABus(m_abus), .M_BE(m_be), .M_DBus(m_dbus),
        .M_RNW(m_rnw), .M_seqAddr(m_seq), .S_DBus(s_dbus), .S_xferAck(s_xfer),
        .S_errAck(s_err), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " sel"},  {m_select, sl_tout}, '0);
        check({tag, " ack"},  {sl_xfer, sl_err, sl_retry}, '0);
        check({tag, " dbus"}, sl_dbus, '0);
    endtask

    task automatic check_mbus(input string tag);
        check({tag, " m_abus_dbus"}, {m_abus, m_dbus}, {exp_mabus, exp_mdbus});
        check({tag, " m_ctl"}, {m_rnw, m_be, m_seq}, {exp_mrnw, exp_mbe, exp_mseq});
    endtask

    // One master transfer. ack_at = ACTIVE cycle of the slave response (0 = never);
    // slv_err raises errAck together with xferAck; abort_at drops OPB_select in that cycle.
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                        input logic [3:0] be, input int ack_at, input logic slv_err,
                        input logic [31:0] rdata, input int abort_at);
        logic hit, timeout, is_err, act, done, seq;
        int idx, endc, last;
        logic [N-1:0] mask;
        hit  = (addr >= BASE) && ((addr - BASE) < N * SPAN);
        idx  = hit ? int'((addr - BASE) / SPAN) : 0;
        mask = hit ? N'(1 << idx) : '0;
        timeout = !(ack_at >= 1 && ack_at <= T);
        endc    = timeout ? T : ack_at;
        is_err  = timeout || slv_err;
        last    = !hit ? 32 : (abort_at > 0 ? abort_at + 1 : endc + 2);
        seq     = 1'($urandom);

        @(negedge clk);
        opb_abus = addr; opb_rnw = rnw; opb_dbus = wdata; opb_be = be;
        opb_seq = seq; opb_select = 1'b1;
        if (hit) begin
            exp_mabus = addr; exp_mdbus = wdata; exp_mbe = be; exp_mrnw = rnw; exp_mseq = seq;
        end
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            act  = hit && c <= (abort_at > 0 ? abort_at : endc);
            done = hit && abort_at == 0 && c == endc + 1;
            if (done && is_err && exp_errs != 16'hFFFF) exp_errs++;
            check("sel", {m_select, sl_tout}, act ? {mask, 1'b1} : '0);
            check("ack", {sl_xfer, sl_err, sl_retry}, {done && !is_err, done && is_err, 1'b0});
            check("sl_dbus", sl_dbus, (done && !is_err && rnw) ? rdata : 32'h0);
            check("err_count", err_count, exp_errs);
            s_xfer = N'($urandom) & ~mask;
            s_err  = N'($urandom) & ~mask;
            for (int i = 0; i < N; i++) s_dbus[i*32 +: 32] = $urandom;
            if (hit) s_dbus[idx*32 +: 32] = rdata;
            if (hit && c == ack_at && !timeout) begin
                s_xfer = s_xfer | mask;
                if (slv_err) s_err = s_err | mask;
            end
            if (c == abort_at || c == endc + 1 || c == last) opb_select = 1'b0;
        end
        check_mbus("hold");
        s_xfer = '0; s_err = '0; opb_select = 1'b0;
    endtask

    task automatic reset_mid(input int slave, input int at);
        @(negedge clk);
        opb_abus = BASE + 32'(slave * SPAN); opb_rnw = 1'b1; opb_select = 1'b1;
        for (int c = 1; c <= at; c++) begin
            @(negedge clk);
            check("rst pre sel", {m_select, sl_tout}, {N'(1 << slave), 1'b1});
        end
        rst_n = 1'b0;
        @(negedge clk);
        exp_errs = '0; exp_mabus = '0; exp_mdbus = '0; exp_mbe = '0; exp_mrnw = 1'b0; exp_mseq = 1'b0;
        check_idle_outputs("rst mid");
        check("rst err_count", err_count, exp_errs);
        check_mbus("rst");
        rst_n = 1'b1; opb_select = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle_outputs("post rst");
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset err_count", err_count, 16'h0);
        check_mbus("reset");
        rst_n = 1'b1;

        xfer(32'h0100E204, 1'b1, $urandom, 4'hF, 3, 1'b0, 32'hDEADBEEF, 0);
        xfer(32'h0100E000, 1'b0, 32'h12345678, 4'hF, 1, 1'b0, $urandom, 0);
        xfer(32'h0100E100, 1'b1, $urandom, 4'hF, 0, 1'b0, $urandom, 0);
        xfer(32'h0100F000, 1'b1, $urandom, 4'hF, 2, 1'b0, $urandom, 0);
        xfer(32'h0100E300, 1'b1, $urandom, 4'h3, 0, 1'b0, $urandom, 2);
        xfer(32'h0100E1F0, 1'b1, $urandom, 4'hF, T, 1'b0, 32'hA5A5C3C3, 0);
        xfer(32'h0100E208, 1'b1, $urandom, 4'hF, 2, 1'b1, 32'h11112222, 0);
        xfer(32'h0100DFFC, 1'b0, $urandom, 4'hF, 1, 1'b0, $urandom, 0);
        xfer(32'h0100E3FF, 1'b1, $urandom, 4'h1, 5, 1'b0, 32'h0BADF00D, 0);
        xfer(32'h0100E400, 1'b1, $urandom, 4'hF, 1, 1'b0, $urandom, 0);
        reset_mid(2, 3);
        xfer(32'h0100E100, 1'b1, $urandom, 4'hF, 4, 1'b0, 32'h600DCAFE, 0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int ack_at, abort_at;
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 64))
                                                : BASE + 32'(N * SPAN) + 32'($urandom_range(0, 4095));
            else
                a = BASE + 32'($urandom_range(0, N - 1) * SPAN) + 32'($urandom_range(0, SPAN - 1));
            abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, T - 1) : 0;
            ack_at   = (abort_at > 0) ? 0 : $urandom_range(0, T + 2);
            xfer(a, 1'($urandom), $urandom, 4'($urandom), ack_at,
                 ($urandom_range(0, 3) == 0), $urandom, abort_at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
